// File: rtl/alu_bitserial_driver_if.sv
// Request/response/slice bundle for the bit-serial ALU sequencer.
// Latency: none (signal grouping only); optional rsp_zero under ALU_SERIAL_ZERO_FLAG_EN.
// Backpressure: req_* and rsp_* are valid/ready; lb_* is a free-running combinational loop.
interface alu_bitserial_driver_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [3:0]       req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_cout;
  logic             rsp_err;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  logic             rsp_zero;
`endif
  logic             lb_a;
  logic             lb_b;
  logic             lb_cin;
  logic [3:0]       lb_opsel;
  logic             lb_result;
  logic             lb_cout;

`ifdef ALU_SERIAL_ZERO_FLAG_EN
  // Environment side: issues requests, consumes responses, models the slice.
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, lb_result, lb_cout,
    input  req_ready, rsp_valid, rsp_result, rsp_cout, rsp_err, rsp_zero,
           lb_a, lb_b, lb_cin, lb_opsel
  );
  // Sequencer side.
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready, lb_result, lb_cout,
    output req_ready, rsp_valid, rsp_result, rsp_cout, rsp_err, rsp_zero,
           lb_a, lb_b, lb_cin, lb_opsel
  );
`else
  // Environment side: issues requests, consumes responses, models the slice.
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, lb_result, lb_cout,
    input  req_ready, rsp_valid, rsp_result, rsp_cout, rsp_err,
           lb_a, lb_b, lb_cin, lb_opsel
  );
  // Sequencer side.
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready, lb_result, lb_cout,
    output req_ready, rsp_valid, rsp_result, rsp_cout, rsp_err,
           lb_a, lb_b, lb_cin, lb_opsel
  );
`endif
endinterface

// File: rtl/alu_bitserial_driver.sv
// Drives an external 1-bit slice LSB-first, WIDTH cycles per op; optional rsp_zero via ALU_SERIAL_ZERO_FLAG_EN.
// Latency: response visible WIDTH+1 cycles after accept (legal op), next cycle for an illegal op.
// Backpressure: one op in flight; req_ready low until the response is taken with rsp_ready.
module alu_bitserial_driver #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_bitserial_driver_if.slave io_bus
);
  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [3:0]       r_op;
  logic             r_cout;
  logic             r_err;
  logic             w_op_legal;
  logic             w_run;
  logic             w_req_hs;

  assign w_run    = (r_state == S_RUN);
  assign w_req_hs = (r_state == S_IDLE) && io_bus.req_valid;

  // Decode which opcodes the slice understands; anything else is answered immediately with an error.
  always_comb begin
    w_op_legal = 1'b0;
    case (io_bus.req_op)
      4'h8, 4'h9, 4'hA, 4'hB, 4'hD: w_op_legal = 1'b1;
      default:                      w_op_legal = 1'b0;
    endcase
  end

  // Sequencer: latch operands on accept, stream one bit per cycle through the slice, hold the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_op     <= 4'h0;
      r_cout   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_hs) begin
            r_a_sr   <= io_bus.req_a;
            r_b_sr   <= io_bus.req_b;
            r_op     <= io_bus.req_op;
            // Clearing the result here keeps stale bits out of both legal and error responses.
            r_res_sr <= '0;
            r_cout   <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_err    <= ~w_op_legal;
            r_state  <= w_op_legal ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_res_sr <= {io_bus.lb_result, r_res_sr[WIDTH-1:1]};
          r_carry  <= io_bus.lb_cout;
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_cout  <= io_bus.lb_cout;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          // A request arriving alongside rsp_ready waits for the IDLE cycle that follows.
          if (io_bus.rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_SERIAL_ZERO_FLAG_EN
  logic r_sticky;

  // Remember whether any result bit was 1 during the current operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_sticky <= 1'b0;
    else if (w_req_hs)  r_sticky <= 1'b0;
    else if (w_run)     r_sticky <= r_sticky | io_bus.lb_result;
  end

  assign io_bus.rsp_zero = (r_state == S_DONE) & ~r_sticky;
`endif

  assign io_bus.req_ready  = (r_state == S_IDLE);
  assign io_bus.rsp_valid  = (r_state == S_DONE);
  assign io_bus.rsp_result = r_res_sr;
  assign io_bus.rsp_cout   = r_cout;
  assign io_bus.rsp_err    = r_err;

  // Slice inputs are only live while streaming bits.
  assign io_bus.lb_a     = w_run & r_a_sr[0];
  assign io_bus.lb_b     = w_run & r_b_sr[0];
  assign io_bus.lb_cin   = w_run & r_carry;
  assign io_bus.lb_opsel = w_run ? r_op : 4'h0;
endmodule

// File: tb/tb_alu_bitserial_driver.sv
// Bench for alu_bitserial_driver: slice model, cycle-level behavioural reference, directed + random ops.
// Timeline model: op accepted at edge T streams bits in cycles T..T+W-1 (edge count), response from T+W.
// Backpressure exercised by random and forced-low rsp_ready.
module tb_alu_bitserial_driver;
  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_bitserial_driver_if #(.WIDTH(W)) bus_if ();

  alu_bitserial_driver #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-bit slice: logic ops return 0 carry; SHL passes cin out as result and A as carry.
  always_comb begin
    bus_if.lb_result = 1'b0;
    bus_if.lb_cout   = 1'b0;
    case (bus_if.lb_opsel)
      4'h8: bus_if.lb_result = bus_if.lb_a & bus_if.lb_b;
      4'h9: bus_if.lb_result = bus_if.lb_a | bus_if.lb_b;
      4'hA: bus_if.lb_result = bus_if.lb_a ^ bus_if.lb_b;
      4'hB: bus_if.lb_result = ~bus_if.lb_a;
      4'hD: begin
        bus_if.lb_result = bus_if.lb_cin;
        bus_if.lb_cout   = bus_if.lb_a;
      end
      default: ;
    endcase
  end

  // Stimulus queue
  logic [W-1:0] q_a[$];
  logic [W-1:0] q_b[$];
  logic [3:0]   q_op[$];

  // Reference model state for the single op in flight
  int           cyc;
  logic         busy;
  int           m_acc;
  logic         m_legal;
  logic [W-1:0] m_a, m_b, m_res;
  logic [3:0]   m_op;
  logic         m_cout, m_err, m_zero;
  logic         seen;
  int           req_pct, rdy_pct, bp_hold, bp_left;

  // Most recent response as observed on the bus
  logic [W-1:0] last_res;
  logic         last_cout, last_err, last_zero;
  int           last_lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    q_a.push_back(a);
    q_b.push_back(b);
    q_op.push_back(op);
  endtask

  // Whole-word reference: what the response must be for an op.
  task automatic model_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    m_err  = 1'b0;
    m_cout = 1'b0;
    m_res  = '0;
    case (op)
      4'h8: m_res = a & b;
      4'h9: m_res = a | b;
      4'hA: m_res = a ^ b;
      4'hB: m_res = ~a;
      4'hD: begin m_res = a << 1; m_cout = a[W-1]; end
      default: m_err = 1'b1;
    endcase
    m_legal = ~m_err;
    m_zero  = m_err | (m_res == '0);
  endtask

  // One cycle: compare at the negedge, drive inputs, advance one edge, update the model.
  task automatic step();
    logic exp_valid, exp_run, req_hs, rsp_hs, do_req, rdy;
    logic [2:0] exp_lb;
    int k;
    exp_valid = busy && (cyc >= m_acc + (m_legal ? W : 0));
    exp_run   = busy && m_legal && (cyc < m_acc + W);
    chk("req_ready", bus_if.req_ready, !busy);
    chk("rsp_valid", bus_if.rsp_valid, exp_valid);
    chk("lb_opsel", bus_if.lb_opsel, exp_run ? m_op : 4'h0);
    exp_lb = 3'b000;
    if (exp_run) begin
      k = cyc - m_acc;
      exp_lb[2] = m_a[k];
      exp_lb[1] = m_b[k];
      exp_lb[0] = (m_op == 4'hD && k > 0) ? m_a[k-1] : 1'b0;
    end
    chk("lb_a_b_cin", {bus_if.lb_a, bus_if.lb_b, bus_if.lb_cin}, exp_lb);
    if (exp_valid) begin
      chk("rsp_result", bus_if.rsp_result, m_res);
      chk("rsp_cout", bus_if.rsp_cout, m_cout);
      chk("rsp_err", bus_if.rsp_err, m_err);
      last_res  = bus_if.rsp_result;
      last_cout = bus_if.rsp_cout;
      last_err  = bus_if.rsp_err;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      chk("rsp_zero", bus_if.rsp_zero, m_zero);
      last_zero = bus_if.rsp_zero;
`endif
      if (!seen) begin
        seen     = 1'b1;
        last_lat = cyc - m_acc + 1;
      end
    end
    do_req = (q_op.size() > 0) && ($urandom_range(0, 99) < req_pct);
    bus_if.req_valid = do_req;
    bus_if.req_a     = do_req ? q_a[0] : W'($urandom);
    bus_if.req_b     = do_req ? q_b[0] : W'($urandom);
    bus_if.req_op    = do_req ? q_op[0] : 4'($urandom);
    req_hs = do_req && !busy;
    if (exp_valid && bp_left > 0) begin
      rdy = 1'b0;
      bp_left--;
    end else begin
      rdy = ($urandom_range(0, 99) < rdy_pct);
    end
    bus_if.rsp_ready = rdy;
    rsp_hs = exp_valid && rdy;
    @(posedge clk);
    cyc++;
    if (rsp_hs) busy = 1'b0;
    if (req_hs) begin
      busy    = 1'b1;
      m_acc   = cyc;
      m_a     = q_a.pop_front();
      m_b     = q_b.pop_front();
      m_op    = q_op.pop_front();
      seen    = 1'b0;
      bp_left = bp_hold;
      model_op(m_a, m_b, m_op);
    end
    @(negedge clk);
  endtask

  task automatic run_all(input int budget);
    int n;
    n = 0;
    while ((q_op.size() > 0 || busy) && n < budget) begin
      step();
      n++;
    end
    if (q_op.size() > 0 || busy) begin
      failures++;
      $display("FAIL timeout: %0d ops still pending after %0d cycles", q_op.size(), budget);
      q_a.delete(); q_b.delete(); q_op.delete();
    end
  endtask

  initial begin
    logic [3:0] legal_ops [5];
    logic [3:0] op;
    int n;
    legal_ops = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hD};
    checks = 0; failures = 0; cyc = 0; busy = 1'b0; seen = 1'b1;
    m_acc = 0; m_legal = 1'b0; m_a = '0; m_b = '0; m_res = '0; m_op = 4'h0;
    m_cout = 1'b0; m_err = 1'b0; m_zero = 1'b0;
    req_pct = 100; rdy_pct = 100; bp_hold = 0; bp_left = 0;
    last_res = '0; last_cout = 1'b0; last_err = 1'b0; last_zero = 1'b0; last_lat = 0;
    rst_n = 1'b0;
    bus_if.req_valid = 1'b0; bus_if.req_a = '0; bus_if.req_b = '0; bus_if.req_op = 4'h0;
    bus_if.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", bus_if.req_ready, 1'b1);
    chk("reset_rsp", {bus_if.rsp_valid, bus_if.rsp_cout, bus_if.rsp_err}, 3'b000);
    chk("reset_result", bus_if.rsp_result, '0);
    chk("reset_lb", {bus_if.lb_a, bus_if.lb_b, bus_if.lb_cin, bus_if.lb_opsel}, 7'h00);
    rst_n = 1'b1;

    // AND with latency pin
    push(32'hFFFF0000, 32'h0F0F0F0F, 4'h8);
    run_all(200);
    chk("and_result", last_res, 32'h0F0F0000);
    chk("and_err", last_err, 1'b0);
    chk("and_latency", last_lat, 33);

    // SHL: top bit falls out as carry
    push(32'h80000001, W'($urandom), 4'hD);
    run_all(200);
    chk("shl_result", last_res, 32'h00000002);
    chk("shl_cout", last_cout, 1'b1);

    // NOT and XOR-with-ones agree
    push(32'h12345678, W'($urandom), 4'hB);
    run_all(200);
    chk("not_result", last_res, 32'hEDCBA987);
    push(32'h12345678, 32'hFFFFFFFF, 4'hA);
    run_all(200);
    chk("xor_result", last_res, 32'hEDCBA987);

    // Illegal opcode answered the next cycle
    push(W'($urandom), W'($urandom), 4'h3);
    run_all(200);
    chk("ill_err", last_err, 1'b1);
    chk("ill_result", last_res, '0);
    chk("ill_latency", last_lat, 1);
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    chk("ill_zero", last_zero, 1'b1);
    push(32'h0, W'($urandom), 4'h8);
    run_all(200);
    chk("and0_zero", last_zero, 1'b1);
`endif

    // Backpressure: response held 10 cycles with the next request already waiting
    bp_hold = 10;
    push(32'hA5A5A5A5, 32'h0000FFFF, 4'h9);
    push(32'h00000000, 32'hFFFFFFFF, 4'h8);
    run_all(300);
    chk("bp_last_result", last_res, 32'h0);
    bp_hold = 0;

    // Random traffic with random stalls on both sides
    req_pct = 70; rdy_pct = 60;
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 4)];
      push(W'($urandom), W'($urandom), op);
    end
    run_all(12000);
    req_pct = 100; rdy_pct = 100;

    // Reset in the middle of bit 17
    push(W'($urandom), W'($urandom), 4'h9);
    n = 0;
    while (!(busy && cyc == m_acc + 17) && n < 100) begin
      step();
      n++;
    end
    chk("reached_bit17", (busy && cyc == m_acc + 17), 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", bus_if.req_ready, 1'b1);
    chk("midrst_rsp", {bus_if.rsp_valid, bus_if.rsp_cout, bus_if.rsp_err}, 3'b000);
    chk("midrst_result", bus_if.rsp_result, '0);
    chk("midrst_lb", {bus_if.lb_a, bus_if.lb_b, bus_if.lb_cin, bus_if.lb_opsel}, 7'h00);
    busy = 1'b0;
    q_a.delete(); q_b.delete(); q_op.delete();
    bus_if.req_valid = 1'b0;
    bus_if.rsp_ready = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    push(32'h0, 32'h5, 4'h9);
    run_all(200);
    chk("post_rst_result", last_res, 32'h00000005);
    chk("post_rst_cout", last_cout, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
